// File: rtl/hba_pkg.sv
// Shared HBA definitions: default bus widths, master state encoding and
// address field helpers.
package hba_pkg;

   localparam int DBUS_WIDTH_DEF        = 8;
   localparam int PERIPH_ADDR_WIDTH_DEF = 4;
   localparam int REG_ADDR_WIDTH_DEF    = 8;
   localparam int ADDR_WIDTH_DEF        = PERIPH_ADDR_WIDTH_DEF + REG_ADDR_WIDTH_DEF;
   localparam int TIMEOUT_CYCLES_DEF    = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } hba_state_e;

   function automatic logic [PERIPH_ADDR_WIDTH_DEF-1:0] addr_periph(
      input logic [ADDR_WIDTH_DEF-1:0] addr);
      return addr[ADDR_WIDTH_DEF-1 -: PERIPH_ADDR_WIDTH_DEF];
   endfunction

   function automatic logic [REG_ADDR_WIDTH_DEF-1:0] addr_reg(
      input logic [ADDR_WIDTH_DEF-1:0] addr);
      return addr[REG_ADDR_WIDTH_DEF-1:0];
   endfunction

endpackage

// File: rtl/hba_timeout_ctr.sv
// XFER-state watchdog: up-counter with clear/enable; tc flags the last
// cycle a slave may ack before the transfer is aborted.
module hba_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic hba_clk,
   input  logic hba_reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/hba_master.sv
// Single-initiator HBA bus master: one request at a time, waits for the
// OR-ed slave xferack or aborts after TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | ready for a host request, bus released
// XFER  | select asserted, waiting for xferack or timeout
// DONE  | response pulse out, select held low one more cycle
module hba_master
   import hba_pkg::*;
#(
   parameter int DBUS_WIDTH        = DBUS_WIDTH_DEF,
   parameter int PERIPH_ADDR_WIDTH = PERIPH_ADDR_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH    = REG_ADDR_WIDTH_DEF,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  req_valid,
   input  logic                  req_rnw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DBUS_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DBUS_WIDTH-1:0] resp_rdata,
   output logic                  resp_timeout,
   input  logic                  hba_xferack,
   input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  hba_select,
   output logic                  hba_rnw,
   output logic [ADDR_WIDTH-1:0] hba_abus,
   output logic [DBUS_WIDTH-1:0] hba_dbus
);

   hba_state_e            state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DBUS_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_timeout_q, resp_timeout_d;
   logic                  hba_select_q, hba_select_d;
   logic                  hba_rnw_q, hba_rnw_d;
   logic [ADDR_WIDTH-1:0] hba_abus_q, hba_abus_d;
   logic [DBUS_WIDTH-1:0] hba_dbus_q, hba_dbus_d;
   logic                  ctr_clr, ctr_en, ctr_tc;

   hba_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_ctr (
      .hba_clk  (hba_clk),
      .hba_reset(hba_reset),
      .clr      (ctr_clr),
      .en       (ctr_en),
      .tc       (ctr_tc)
   );

   always_comb begin
      state_d        = state_q;
      req_ready_d    = req_ready_q;
      resp_valid_d   = resp_valid_q;
      resp_rdata_d   = resp_rdata_q;
      resp_timeout_d = resp_timeout_q;
      hba_select_d   = hba_select_q;
      hba_rnw_d      = hba_rnw_q;
      hba_abus_d     = hba_abus_q;
      hba_dbus_d     = hba_dbus_q;
      ctr_clr        = 1'b0;
      ctr_en         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready_d    = 1'b1;
            resp_valid_d   = 1'b0;
            resp_timeout_d = 1'b0;
            hba_select_d   = 1'b0;
            hba_rnw_d      = 1'b0;
            hba_abus_d     = '0;
            hba_dbus_d     = '0;
            // req_ready_q gates acceptance so the first post-reset cycle is skipped
            if (req_valid && req_ready_q) begin
               req_ready_d  = 1'b0;
               hba_select_d = 1'b1;
               hba_rnw_d    = req_rnw;
               hba_abus_d   = req_addr;
               hba_dbus_d   = req_rnw ? '0 : req_wdata;
               ctr_clr      = 1'b1;
               state_d      = ST_XFER;
            end
         end
         ST_XFER: begin
            req_ready_d = 1'b0;
            ctr_en      = 1'b1;
            if (hba_xferack || ctr_tc) begin
               hba_select_d   = 1'b0;
               hba_rnw_d      = 1'b0;
               hba_abus_d     = '0;
               hba_dbus_d     = '0;
               resp_valid_d   = 1'b1;
               resp_timeout_d = !hba_xferack;
               resp_rdata_d   = (hba_xferack && hba_rnw_q) ? hba_dbus_slave : '0;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            req_ready_d    = 1'b1;
            resp_valid_d   = 1'b0;
            resp_timeout_d = 1'b0;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         state_q        <= ST_IDLE;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_timeout_q <= 1'b0;
         hba_select_q   <= 1'b0;
         hba_rnw_q      <= 1'b0;
         hba_abus_q     <= '0;
         hba_dbus_q     <= '0;
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_timeout_q <= resp_timeout_d;
         hba_select_q   <= hba_select_d;
         hba_rnw_q      <= hba_rnw_d;
         hba_abus_q     <= hba_abus_d;
         hba_dbus_q     <= hba_dbus_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_rdata   = resp_rdata_q;
   assign resp_timeout = resp_timeout_q;
   assign hba_select   = hba_select_q;
   assign hba_rnw      = hba_rnw_q;
   assign hba_abus     = hba_abus_q;
   assign hba_dbus     = hba_dbus_q;

endmodule

// File: tb/tb_hba_master.sv
// Bench for hba_master with a register-bank slave model at peripheral 1
// and a response scoreboard.
module tb_hba_master;
   import hba_pkg::*;

   localparam int TO = 16;

   logic        hba_clk = 1'b0;
   logic        hba_reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_rnw = 1'b0;
   logic [11:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready, resp_valid, resp_timeout;
   logic [7:0]  resp_rdata;
   logic        hba_xferack;
   logic [7:0]  hba_dbus_slave;
   logic        hba_select, hba_rnw;
   logic [11:0] hba_abus;
   logic [7:0]  hba_dbus;

   logic        inj_ack = 1'b0;
   logic [7:0]  inj_data = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int resp_cnt = 0;
   int ready_viol = 0;
   int low_run = 0;
   int last_gap = 0;
   int last_acc = 0;

   typedef struct {
      logic [7:0] rdata;
      logic       to;
      int         lat;
      int         acc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic       rnw;
      logic [11:0] addr;
      logic [7:0] wdata;
      logic [7:0] erd;
      logic       eto;
      int         lat;
   } vec_t;
   vec_t vecs[8];

   hba_master #(
      .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
      .ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)
   ) dut (
      .hba_clk(hba_clk), .hba_reset(hba_reset),
      .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
      .hba_xferack(hba_xferack), .hba_dbus_slave(hba_dbus_slave),
      .hba_select(hba_select), .hba_rnw(hba_rnw), .hba_abus(hba_abus),
      .hba_dbus(hba_dbus)
   );

   always #5 hba_clk = ~hba_clk;
   always @(posedge hba_clk) cyc <= cyc + 1;

   // Register-bank slave: addr_hit, access, then one-cycle xferack.
   logic [2:0] sl_stage;
   logic [7:0] sl_regs[4];
   logic [7:0] sl_rd;
   wire  [7:0] sl_idx = addr_reg(hba_abus);

   always @(posedge hba_clk) begin
      if (hba_reset) begin
         sl_stage <= 3'd0;
         sl_rd <= 8'h00;
         for (int i = 0; i < 4; i++) sl_regs[i] <= 8'h00;
      end else begin
         case (sl_stage)
            3'd0: if (hba_select && addr_periph(hba_abus) == 4'h1) sl_stage <= 3'd1;
            3'd1: sl_stage <= hba_select ? 3'd2 : 3'd0;
            3'd2: begin
               if (hba_select) begin
                  sl_stage <= 3'd3;
                  if (hba_rnw) sl_rd <= (sl_idx < 8'd4) ? sl_regs[sl_idx[1:0]] : 8'h00;
                  else if (sl_idx < 8'd4) sl_regs[sl_idx[1:0]] <= hba_dbus;
               end else begin
                  sl_stage <= 3'd0;
               end
            end
            3'd3: sl_stage <= 3'd4;
            default: if (!hba_select) sl_stage <= 3'd0;
         endcase
      end
   end

   assign hba_xferack    = (sl_stage == 3'd3) | inj_ack;
   assign hba_dbus_slave = ((sl_stage == 3'd3) ? sl_rd : 8'h00) | inj_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge hba_clk) begin
      if (!hba_select) low_run++;
      else begin
         if (low_run != 0) last_gap = low_run;
         low_run = 0;
      end
      if ((hba_select || resp_valid) && req_ready) ready_viol++;
      if (resp_valid) begin
         resp_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rdata});
            check("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.to});
            check("resp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic issue(input logic rnw, input logic [11:0] addr, input logic [7:0] wdata,
                        input logic [7:0] erd, input logic eto, input int lat, input bit keep);
      int n = 0;
      exp_t e;
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 100) begin
         @(negedge hba_clk);
         n++;
      end
      if (!req_ready) begin
         check("req_ready_wait", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge hba_clk);
      @(negedge hba_clk);
      e.rdata = erd; e.to = eto; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
      last_acc = cyc;
      check("select_after_accept", {31'd0, hba_select}, 32'd1);
      check("abus_after_accept", {20'd0, hba_abus}, {20'd0, addr});
      check("rnw_after_accept", {31'd0, hba_rnw}, {31'd0, rnw});
      check("dbus_after_accept", {24'd0, hba_dbus}, {24'd0, rnw ? 8'h00 : wdata});
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge hba_clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("resp_wait", 32'd0, 32'd1);
         sb.delete();
      end
      @(negedge hba_clk);
   endtask

   initial begin
      int acc1, cnt0;
      vecs[0] = '{1'b0, 12'h102, 8'h5A, 8'h00, 1'b0, 4};
      vecs[1] = '{1'b1, 12'h102, 8'h00, 8'h5A, 1'b0, 4};
      vecs[2] = '{1'b1, 12'h107, 8'h00, 8'h00, 1'b0, 4};
      vecs[3] = '{1'b0, 12'h103, 8'hA5, 8'h00, 1'b0, 4};
      vecs[4] = '{1'b1, 12'h103, 8'h00, 8'hA5, 1'b0, 4};
      vecs[5] = '{1'b1, 12'hF00, 8'h00, 8'h00, 1'b1, TO};
      vecs[6] = '{1'b0, 12'h200, 8'h11, 8'h00, 1'b1, TO};
      vecs[7] = '{1'b1, 12'h102, 8'h00, 8'h5A, 1'b0, 4};

      repeat (3) @(negedge hba_clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_outputs", {20'd0, resp_valid, resp_timeout, hba_select, hba_rnw, resp_rdata},
            32'd0);
      check("rst_bus", {8'd0, hba_abus, 4'd0, hba_dbus}, 32'd0);
      hba_reset = 1'b0;
      @(negedge hba_clk);
      check("ready_after_reset", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].erd, vecs[i].eto,
               vecs[i].lat, 1'b0);
         wait_done();
         if (vecs[i].eto) check("select_low_after_timeout", {31'd0, hba_select}, 32'd0);
      end

      // Back-to-back with req_valid held high
      issue(1'b0, 12'h101, 8'h33, 8'h00, 1'b0, 4, 1'b1);
      acc1 = last_acc;
      issue(1'b1, 12'h101, 8'h00, 8'h33, 1'b0, 4, 1'b0);
      check("b2b_accept_spacing", last_acc - acc1, 6);
      wait_done();
      check("b2b_select_gap", last_gap, 2);

      // Stale xferack while idle
      cnt0 = resp_cnt;
      inj_ack = 1'b1;
      inj_data = 8'hFF;
      repeat (3) @(negedge hba_clk);
      check("inject_no_select", {31'd0, hba_select}, 32'd0);
      check("inject_ready", {31'd0, req_ready}, 32'd1);
      inj_ack = 1'b0;
      inj_data = 8'h00;
      repeat (2) @(negedge hba_clk);
      check("inject_no_resp", resp_cnt, cnt0);
      check("rdata_holds", {24'd0, resp_rdata}, 32'h33);

      // Reset two cycles into XFER
      issue(1'b1, 12'h102, 8'h00, 8'h00, 1'b0, 4, 1'b0);
      cnt0 = resp_cnt;
      @(negedge hba_clk);
      hba_reset = 1'b1;
      @(negedge hba_clk);
      sb.delete();
      check("reset_select_drop", {31'd0, hba_select}, 32'd0);
      check("reset_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge hba_clk);
      hba_reset = 1'b0;
      @(negedge hba_clk);
      check("ready_after_midreset", {31'd0, req_ready}, 32'd1);
      repeat (6) @(negedge hba_clk);
      check("midreset_no_resp", resp_cnt, cnt0);
      issue(1'b0, 12'h102, 8'h77, 8'h00, 1'b0, 4, 1'b0);
      wait_done();
      issue(1'b1, 12'h102, 8'h00, 8'h77, 1'b0, 4, 1'b0);
      wait_done();

      check("ready_low_while_busy", ready_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, limit reached");
      $fatal(1);
   end

endmodule
